// File: rtl/mlp_loader_pkg.sv
// Shared types and sizing helpers for the MLP feature loader.
// Optional frame checking is enabled with MLP_LOADER_FRAME_CHECK_EN.
package mlp_loader_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int DEF_NUM_A = 11;

    // Counter width that stays >= 1 bit for degenerate sizes.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FCNT_W = cnt_bits(DEF_NUM_A);

endpackage

// File: rtl/mlp_feature_packer.sv
// Slot register file and feature counter feeding the classifier input.
// With CHECK set, a misplaced frame-end marker aborts the partial sample.
module mlp_feature_packer
    import mlp_loader_pkg::*;
#(
    parameter int NUM_A   = 11,
    parameter int WIDTH_A = 4,
    parameter bit CHECK   = 1'b0,
    parameter int FW      = cnt_bits(NUM_A)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH_A-1:0]       wr_data,
    input  logic                     wr_last,
    output logic [NUM_A*WIDTH_A-1:0] inp,
    output logic                     done,
    output logic                     bad
);

    logic [FW-1:0] fcnt;
    logic          at_last;

    assign at_last = (fcnt == FW'(NUM_A - 1));
    assign bad     = CHECK && wr_en && (wr_last != at_last);
    assign done    = wr_en && at_last && !bad;

    // Slots are only overwritten, never cleared between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            inp  <= '0;
            fcnt <= '0;
        end else begin
            for (int k = 0; k < NUM_A; k++) begin
                if (wr_en && fcnt == FW'(k))
                    inp[k*WIDTH_A +: WIDTH_A] <= wr_data;
            end
            if (done || bad)
                fcnt <= '0;
            else if (wr_en)
                fcnt <= fcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mlp_feature_loader.sv
// Packs streamed features for the printed MLP, settles, returns the class.
// Define MLP_LOADER_FRAME_CHECK_EN to add s_last framing and err_frame.
module mlp_feature_loader
    import mlp_loader_pkg::*;
#(
    parameter int NUM_A         = 11,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH_A-1:0]       s_data,
`ifdef MLP_LOADER_FRAME_CHECK_EN
    input  logic                     s_last,
    output logic                     err_frame,
`endif
    output logic [NUM_A*WIDTH_A-1:0] inp,
    input  logic [OUTWIDTH-1:0]      cls,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUTWIDTH-1:0]      m_class,
    output logic [IDX_W-1:0]         m_index,
    output logic                     busy
);

    localparam int          SW    = cnt_bits(SETTLE_CYCLES);
    localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES - 1);

    state_t           state, state_nx;
    logic [SW-1:0]    scnt;
    logic [IDX_W-1:0] scount;
    logic             accept;
    logic             done;
    logic             bad;
    logic             last_in;

`ifdef MLP_LOADER_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
    assign last_in = s_last;

    always_ff @(posedge clk) begin
        if (rst)
            err_frame <= 1'b0;
        else
            err_frame <= bad;
    end
`else
    localparam bit FRAME_CHECK = 1'b0;
    logic unused_bad;
    assign last_in    = 1'b0;
    assign unused_bad = bad;
`endif

    assign s_ready = (state == LOAD);
    assign busy    = (state != LOAD);
    assign accept  = s_valid && s_ready;

    mlp_feature_packer #(
        .NUM_A   (NUM_A),
        .WIDTH_A (WIDTH_A),
        .CHECK   (FRAME_CHECK)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (s_data),
        .wr_last (last_in),
        .inp     (inp),
        .done    (done),
        .bad     (bad)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (done) state_nx = SETTLE;
            SETTLE:  if (scnt == '0) state_nx = OUT;
            OUT:     if (m_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Class is captured on the edge where the settle counter reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt    <= '0;
            scount  <= '0;
            m_valid <= 1'b0;
            m_class <= '0;
            m_index <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (done) scnt <= SLOAD;
                end
                SETTLE: begin
                    if (scnt == '0) begin
                        m_class <= cls;
                        m_index <= scount;
                        m_valid <= 1'b1;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        scount  <= scount + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Directed bench for mlp_feature_loader with a modulo-7 stand-in classifier.
// Frame-check sequence runs only when MLP_LOADER_FRAME_CHECK_EN is defined.
module tb_mlp_feature_loader;

    typedef struct {
        logic [3:0]  f [11];
        logic [43:0] exp_inp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready, s_ready2;
    logic [3:0]  s_data;
    logic        s_last;
    logic [43:0] inp, inp2;
    logic [2:0]  cls, cls2;
    logic        m_valid, m_valid2;
    logic        m_ready;
    logic [2:0]  m_class, m_class2;
    logic [15:0] m_index;
    logic [1:0]  m_index2;
    logic        busy, busy2;
`ifdef MLP_LOADER_FRAME_CHECK_EN
    logic        err_frame, err_frame2;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_idx  = 0;
    int   rise_cyc = 0;
    int   prev_rise;
    vec_t tbl [5];

    function automatic logic [2:0] cls_of(input logic [43:0] v);
        return 3'(v % 44'd7);
    endfunction

    assign cls  = cls_of(inp);
    assign cls2 = cls_of(inp2);

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mlp_feature_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef MLP_LOADER_FRAME_CHECK_EN
        .s_last    (s_last),
        .err_frame (err_frame),
`endif
        .inp       (inp),
        .cls       (cls),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_class   (m_class),
        .m_index   (m_index),
        .busy      (busy)
    );

    mlp_feature_loader #(.IDX_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready2),
        .s_data    (s_data),
`ifdef MLP_LOADER_FRAME_CHECK_EN
        .s_last    (s_last),
        .err_frame (err_frame2),
`endif
        .inp       (inp2),
        .cls       (cls2),
        .m_valid   (m_valid2),
        .m_ready   (m_ready),
        .m_class   (m_class2),
        .m_index   (m_index2),
        .busy      (busy2)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic feed(input int vi, input int n, input int last_at);
        int t;
        for (int k = 0; k < n; k++) begin
            s_data  = tbl[vi].f[k];
            s_last  = (k == last_at);
            s_valid = 1'b1;
            t = 0;
            while (!s_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) chk("feed_timeout", 1, 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_sample(input int vi);
        int lat = 0;
        feed(vi, 11, 10);
        while (!m_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        prev_rise = rise_cyc;
        rise_cyc  = cyc;
        chk("latency", 64'(lat), 64'd2);
        chk("inp", 64'(inp), 64'(tbl[vi].exp_inp));
        chk("m_class", 64'(m_class), 64'(cls_of(tbl[vi].exp_inp)));
        chk("m_index", 64'(m_index), 64'(exp_idx));
        chk("m_index_w2", 64'(m_index2), 64'(exp_idx % 4));
        chk("busy_out", 64'(busy), 64'd1);
    endtask

    task automatic chk_reset_state();
        chk("rst_inp", 64'(inp), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_class", 64'(m_class), 64'd0);
        chk("rst_m_index", 64'(m_index), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fcnt", 64'(dut.u_packer.fcnt), 64'd0);
        chk("rst_m_index_w2", 64'(m_index2), 64'd0);
`ifdef MLP_LOADER_FRAME_CHECK_EN
        chk("rst_err_frame", 64'(err_frame), 64'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            tbl[0].f[k] = 4'(k + 1);
            tbl[1].f[k] = 4'hF;
            tbl[2].f[k] = 4'h0;
            tbl[3].f[k] = 4'(10 - k);
            tbl[4].f[k] = (k % 2 == 0) ? 4'h5 : 4'hA;
        end
        tbl[0].exp_inp = 44'hBA987654321;
        tbl[1].exp_inp = 44'hFFFFFFFFFFF;
        tbl[2].exp_inp = 44'h00000000000;
        tbl[3].exp_inp = 44'h0123456789A;
        tbl[4].exp_inp = 44'h5A5A5A5A5A5;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state();

        // First sample, result held while the consumer stalls.
        run_sample(0);
        s_valid = 1'b1;
        s_data  = 4'hF;
        repeat (10) begin
            @(posedge clk); #1;
            chk("stall_m_valid", 64'(m_valid), 64'd1);
            chk("stall_m_class", 64'(m_class), 64'(cls_of(tbl[0].exp_inp)));
            chk("stall_m_index", 64'(m_index), 64'd0);
            chk("stall_s_ready", 64'(s_ready), 64'd0);
            chk("stall_fcnt", 64'(dut.u_packer.fcnt), 64'd0);
            chk("stall_inp", 64'(inp), 64'(tbl[0].exp_inp));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("hs_m_valid", 64'(m_valid), 64'd0);
        chk("hs_s_ready", 64'(s_ready), 64'd1);
        exp_idx++;

        // Back-to-back samples with the consumer always ready.
        m_ready = 1'b1;
        for (int vi = 1; vi <= 3; vi++) begin
            run_sample(vi);
            if (vi > 1) chk("spacing", 64'(rise_cyc - prev_rise), 64'd14);
            exp_idx++;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("drain_m_valid", 64'(m_valid), 64'd0);

        // Reset in the middle of a partial sample.
        feed(0, 5, 99);
        chk("partial_fcnt", 64'(dut.u_packer.fcnt), 64'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state();
        exp_idx = 0;

`ifdef MLP_LOADER_FRAME_CHECK_EN
        // Early frame end on the sixth feature aborts the sample.
        feed(4, 6, 5);
        chk("abort_err", 64'(err_frame), 64'd1);
        chk("abort_fcnt", 64'(dut.u_packer.fcnt), 64'd0);
        chk("abort_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        chk("abort_err_pulse", 64'(err_frame), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(m_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
`endif

        // Five samples after reset; the 2-bit index wraps on the fifth.
        m_ready = 1'b1;
        for (int vi = 0; vi < 5; vi++) begin
            run_sample(vi);
            exp_idx++;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("final_m_valid", 64'(m_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
